// File: rtl/lag_counter.sv
// lag_counter: display-lag meter; counts BCD ticks from starttrigger to the filtered photo-sensor rise.
// Optional LAG_MIN_EN macro adds min_bcdcount, the smallest valid result since reset.
module lag_counter #(
  parameter int unsigned TICK_DIV      = 100,
  parameter int unsigned SENSOR_FILTER = 16,
  parameter logic [23:0] TIMEOUT_BCD   = 24'h999999
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        starttrigger,
  input  logic        sensor,
  output logic [23:0] bcdcount,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout
`ifdef LAG_MIN_EN
  ,
  output logic [23:0] min_bcdcount
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (SENSOR_FILTER > 1) ? $clog2(SENSOR_FILTER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(SENSOR_FILTER - 1);

  typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1, sync2, filt;
  logic [FW-1:0] fcnt;
  logic          detect;
  logic [PW-1:0] presc;
  logic [23:0]   count, count_next;
  logic          tick, counting, timeout_hit;

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Filtered level flips on the SENSOR_FILTER-th consecutive differing synced sample.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      fcnt  <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      if (sync2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FILT_LAST) begin
        filt <= sync2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    detect      = ~filt & sync2 & (fcnt == FILT_LAST);
    counting    = (state_q == COUNTING);
    tick        = (presc == PRESC_LAST);
    count_next  = tick ? bcd_inc(count) : count;
    timeout_hit = counting & (count == TIMEOUT_BCD);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (starttrigger) state_d = COUNTING;
      COUNTING: begin
        if (starttrigger)                state_d = COUNTING;
        else if (timeout_hit || detect)  state_d = DONE;
      end
      DONE:     if (starttrigger) state_d = COUNTING;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == COUNTING);
  end

  // The result includes a tick landing on the detect edge itself, giving floor(N/TICK_DIV).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc        <= '0;
      count        <= '0;
      bcdcount     <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
`ifdef LAG_MIN_EN
      min_bcdcount <= 24'h999999;
`endif
    end else begin
      result_valid <= 1'b0;
      if (starttrigger) begin
        presc <= '0;
        count <= '0;
      end else if (counting) begin
        if (timeout_hit) begin
          bcdcount <= 24'h999999;
          timeout  <= 1'b1;
        end else begin
          presc <= tick ? '0 : presc + PW'(1);
          count <= count_next;
          if (detect) begin
            bcdcount     <= count_next;
            result_valid <= 1'b1;
            timeout      <= 1'b0;
`ifdef LAG_MIN_EN
            if (count_next < min_bcdcount) min_bcdcount <= count_next;
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lag_counter.sv
// tb_lag_counter: two lag_counter configurations share stimulus; a tick/window reference model
// predicts each measurement outcome into per-DUT queues that a negedge monitor checks.
module tb_lag_counter;

  localparam int SF = 3;

  typedef struct {
    bit          valid;
    logic [23:0] value;
    bit          to;
    logic [23:0] mn;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic starttrigger = 1'b0;
  logic sensor = 1'b0;

  logic [23:0] bcd [0:1];
  logic        rv  [0:1];
  logic        bz  [0:1];
  logic        tmo [0:1];
`ifdef LAG_MIN_EN
  logic [23:0] mins [0:1];
`endif

  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q [0:1][$];
  int   td [0:1] = '{4, 1};
  int   vv [0:1] = '{50, 999999};
  bit   open [0:1] = '{1'b0, 1'b0};
  int   t0 [0:1] = '{0, 0};
  logic [23:0] mn [0:1] = '{24'h999999, 24'h999999};
  bit   bprev [0:1] = '{1'b0, 1'b0};
  bit   hist [$];
  bit   win [$];
  bit   filt_m = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;

  lag_counter #(.TICK_DIV(4), .SENSOR_FILTER(SF), .TIMEOUT_BCD(24'h000050)) dut_a (
    .clock(clock), .reset_n(reset_n), .starttrigger(starttrigger), .sensor(sensor),
    .bcdcount(bcd[0]), .result_valid(rv[0]), .busy(bz[0]), .timeout(tmo[0])
`ifdef LAG_MIN_EN
    , .min_bcdcount(mins[0])
`endif
  );

  lag_counter #(.TICK_DIV(1), .SENSOR_FILTER(SF), .TIMEOUT_BCD(24'h999999)) dut_b (
    .clock(clock), .reset_n(reset_n), .starttrigger(starttrigger), .sensor(sensor),
    .bcdcount(bcd[1]), .result_valid(rv[1]), .busy(bz[1]), .timeout(tmo[1])
`ifdef LAG_MIN_EN
    , .min_bcdcount(mins[1])
`endif
  );

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", nm, d, act, exp, cyc);
    end
  endtask

  // Reference model: a measurement ends at the first of detect, timeout (TD*V+1 edges after
  // acceptance), retrigger or reset; a detect reports floor(elapsed/TD).
  always @(posedge clock) begin
    bit          y, det, same;
    int          val;
    logic [23:0] res;
    cyc++;
    if (!reset_n) begin
      hist.delete();
      win.delete();
      filt_m = 1'b0;
      for (int d = 0; d < 2; d++) begin
        mn[d] = 24'h999999;
        if (open[d]) q[d].push_back('{valid: 1'b0, value: 24'h0, to: 1'b0, mn: mn[d]});
        open[d] = 1'b0;
      end
    end else begin
      y = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(sensor);
      if (hist.size() > 2) void'(hist.pop_front());
      win.push_back(y);
      if (win.size() > SF) void'(win.pop_front());
      det = 1'b0;
      if (win.size() == SF) begin
        same = 1'b1;
        foreach (win[i]) if (win[i] != y) same = 1'b0;
        if (same && (y != filt_m)) begin
          filt_m = y;
          det    = y;
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (starttrigger) begin
          open[d] = 1'b1;
          t0[d]   = cyc;
        end else if (open[d]) begin
          if (cyc - t0[d] == td[d] * vv[d] + 1) begin
            q[d].push_back('{valid: 1'b0, value: 24'h999999, to: 1'b1, mn: mn[d]});
            open[d] = 1'b0;
          end else if (det) begin
            val = (cyc - t0[d]) / td[d];
            res = to_bcd(val);
            if (res < mn[d]) mn[d] = res;
            q[d].push_back('{valid: 1'b1, value: res, to: 1'b0, mn: mn[d]});
            open[d] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      chk("busy", d, 24'(bz[d]), 24'(open[d]));
      if (bprev[d] && !bz[d]) begin
        chk("end_expected", d, 24'(q[d].size() > 0), 24'(1));
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          chk("result_valid", d, 24'(rv[d]), 24'(e.valid));
          chk("bcdcount", d, bcd[d], e.value);
          chk("timeout", d, 24'(tmo[d]), 24'(e.to));
`ifdef LAG_MIN_EN
          chk("min_bcdcount", d, mins[d], e.mn);
`endif
        end
      end else begin
        chk("stray_valid", d, 24'(rv[d]), 24'(0));
      end
      bprev[d] = bz[d];
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic trig();
    starttrigger = 1'b1;
    step(1);
    starttrigger = 1'b0;
  endtask

  task automatic pulse(input int len, input int low);
    sensor = 1'b1;
    step(len);
    sensor = 1'b0;
    step(low);
  endtask

  // Trigger, then raise the sensor so the detect edge lands n clocks after acceptance.
  task automatic meas(input int n);
    trig();
    step(n - 2 - SF);
    pulse(SF + 3, SF + 5);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_bcdcount", d, bcd[d], 24'h0);
      chk("rst_valid", d, 24'(rv[d]), 24'(0));
      chk("rst_busy", d, 24'(bz[d]), 24'(0));
      chk("rst_timeout", d, 24'(tmo[d]), 24'(0));
`ifdef LAG_MIN_EN
      chk("rst_min", d, mins[d], 24'h999999);
`endif
    end
  endtask

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    check_reset_outputs();

    meas(45);
    meas(100);
    trig();
    step(230);
    meas(30);
    trig();
    step(10);
    pulse(2, 10);
    pulse(5, 8);
    trig();
    step(19);
    meas(45);

    trig();
    step(30);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check_reset_outputs();
    step(2);

    meas(120);
    meas(48);
    meas(80);
`ifdef LAG_MIN_EN
    chk("min_after_three", 0, mins[0], 24'h000012);
`endif

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: meas($urandom_range(6, 260));
        1: begin
          trig();
          step($urandom_range(1, 150));
          meas($urandom_range(6, 120));
        end
        2: begin
          trig();
          step($urandom_range(0, 20));
          pulse($urandom_range(1, SF - 1), $urandom_range(2, 10));
          pulse(SF + 2, SF + 5);
        end
        default: begin
          pulse(SF + 2, SF + 5);
          step($urandom_range(0, 5));
        end
      endcase
    end

    step(30);
    for (int d = 0; d < 2; d++) chk("queue_drained", d, 24'(q[d].size()), 24'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
